period_meter: RTL and testbench

- Downstream consumer of the zero-crossing detector in the interpolator chain.
- Takes the per-crossing `flag` pulse and the running sample counter `cnt`, and turns them into a measured signal period in clk cycles.
- Rejects glitch and out-of-range periods, averages 2^LOG2_AVG accepted periods, and flags loss of signal via a timeout.
- Its outputs drive the interpolator step computation.

---
 rtl/period_meter_if.sv | 46 ++++
 rtl/period_meter.sv | 159 +++++++++++++++
 tb/tb_period_meter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - flag/counter input and measurement result bundle for period_meter
//
// Purpose: groups the zero-crossing input (flag, cnt) and the measurement
//          results into one interface.
// Modports:
//   master : upstream/consumer side (drives flag, cnt; receives results)
//   slave  : period_meter side (receives flag, cnt; drives results)
// Signals:
//   flag       1   one-cycle pulse at each negative-going zero crossing
//   cnt        10  upstream sample counter, 0 in the flag cycle
//   period     11  last accepted single period
//   period_avg 11  average of the last 2^LOG2_AVG accepted periods
//   avg_valid  1   one-cycle strobe, period_avg updated in the same cycle
//   locked     1   at least one average completed since reset or loss
//   lost       1   timeout occurred, no valid measurement
//   reject_cnt 8   saturating count of rejected periods
//   jitter     11  max-min of the window (only with PERIOD_METER_JITTER_EN)
interface period_meter_if;
   logic        flag;
   logic [9:0]  cnt;
   logic [10:0] period;
   logic [10:0] period_avg;
   logic        avg_valid;
   logic        locked;
   logic        lost;
   logic [7:0]  reject_cnt;
`ifdef PERIOD_METER_JITTER_EN
   logic [10:0] jitter;
`endif

   modport master (
      output flag, cnt,
      input  period, period_avg, avg_valid, locked, lost, reject_cnt
`ifdef PERIOD_METER_JITTER_EN
      , input jitter
`endif
   );

   modport slave (
      input  flag, cnt,
      output period, period_avg, avg_valid, locked, lost, reject_cnt
`ifdef PERIOD_METER_JITTER_EN
      , output jitter
`endif
   );
endinterface

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures, filters and averages the zero-crossing period
//
// Purpose: turns the per-crossing flag pulse and the upstream running counter
//          into a measured period in clk cycles. Periods outside
//          [P_MIN, P_MAX] are rejected and counted, 2^LOG2_AVG accepted
//          periods are averaged, and a missing flag for TIMEOUT cycles
//          declares the input lost.
// Optional feature: define PERIOD_METER_JITTER_EN to add pm.jitter, the
//          max-min spread of the accepted periods in each averaging window.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   pm     period_meter_if.slave (flag, cnt in; period, period_avg,
//          avg_valid, locked, lost, reject_cnt [, jitter] out)
module period_meter #(
   parameter int LOG2_AVG = 2,
   parameter int P_MIN    = 4,
   parameter int P_MAX    = 1000,
   parameter int TIMEOUT  = 1100
) (
   input logic           clk,
   input logic           rst_n,
   period_meter_if.slave pm
);
   // Sum of 2^LOG2_AVG periods of at most 1024 each always fits.
   localparam int ACC_W = 11 + LOG2_AVG;
   localparam logic [LOG2_AVG-1:0] K_LAST = '1;

   typedef enum logic {WAIT_FIRST, MEASURE} state_t;

   state_t              state;
   logic [9:0]          cnt_q;
   logic [ACC_W-1:0]    acc;
   logic [LOG2_AVG-1:0] k;
   logic [10:0]         tmo;
   logic [10:0]         period_r;
   logic [10:0]         avg_r;
   logic                avg_valid_r;
   logic                locked_r;
   logic                lost_r;
   logic [7:0]          rej_r;

   logic [10:0]         p_raw;
   logic                p_ok;
   logic [ACC_W-1:0]    acc_sum;
   logic                tmo_hit;

   // cnt_q holds the count of the cycle before the flag, so +1 is the period;
   // computed 11 bits wide so a wrapped 1023 gives 1024.
   assign p_raw   = {1'b0, cnt_q} + 11'd1;
   assign p_ok    = (p_raw >= 11'(P_MIN)) && (p_raw <= 11'(P_MAX));
   assign acc_sum = acc + ACC_W'(p_raw);
   // Fires on the edge where the counter would reach TIMEOUT; a flag on that
   // same edge takes priority in the state machine below.
   assign tmo_hit = ((tmo + 11'd1) == 11'(TIMEOUT));

`ifdef PERIOD_METER_JITTER_EN
   logic [10:0] run_min;
   logic [10:0] run_max;
   logic [10:0] new_min;
   logic [10:0] new_max;
   logic [10:0] jitter_r;

   assign new_min = (p_raw < run_min) ? p_raw : run_min;
   assign new_max = (p_raw > run_max) ? p_raw : run_max;
   assign pm.jitter = jitter_r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_FIRST;
         cnt_q       <= '0;
         acc         <= '0;
         k           <= '0;
         tmo         <= '0;
         period_r    <= '0;
         avg_r       <= '0;
         avg_valid_r <= 1'b0;
         locked_r    <= 1'b0;
         lost_r      <= 1'b0;
         rej_r       <= '0;
`ifdef PERIOD_METER_JITTER_EN
         run_min     <= '1;
         run_max     <= '0;
         jitter_r    <= '0;
`endif
      end else begin
         cnt_q       <= pm.cnt;
         avg_valid_r <= 1'b0;

         if (pm.flag) begin
            tmo <= '0;
         end else if (tmo != '1) begin
            tmo <= tmo + 11'd1;
         end

         case (state)
            WAIT_FIRST: begin
               // First flag only marks the start of a measurement interval.
               if (pm.flag) begin
                  state  <= MEASURE;
                  acc    <= '0;
                  k      <= '0;
                  lost_r <= 1'b0;
`ifdef PERIOD_METER_JITTER_EN
                  run_min <= '1;
                  run_max <= '0;
`endif
               end
            end
            MEASURE: begin
               if (pm.flag) begin
                  if (p_ok) begin
                     period_r <= p_raw;
                     if (k == K_LAST) begin
                        avg_r       <= acc_sum[ACC_W-1:LOG2_AVG];
                        avg_valid_r <= 1'b1;
                        locked_r    <= 1'b1;
                        acc         <= '0;
                        k           <= '0;
`ifdef PERIOD_METER_JITTER_EN
                        jitter_r    <= new_max - new_min;
                        run_min     <= '1;
                        run_max     <= '0;
`endif
                     end else begin
                        acc <= acc_sum;
                        k   <= k + LOG2_AVG'(1);
`ifdef PERIOD_METER_JITTER_EN
                        run_min <= new_min;
                        run_max <= new_max;
`endif
                     end
                  end else if (rej_r != '1) begin
                     rej_r <= rej_r + 8'd1;
                  end
               end else if (tmo_hit) begin
                  lost_r   <= 1'b1;
                  locked_r <= 1'b0;
                  state    <= WAIT_FIRST;
                  acc      <= '0;
                  k        <= '0;
`ifdef PERIOD_METER_JITTER_EN
                  run_min  <= '1;
                  run_max  <= '0;
`endif
               end
            end
         endcase
      end
   end

   assign pm.period     = period_r;
   assign pm.period_avg = avg_r;
   assign pm.avg_valid  = avg_valid_r;
   assign pm.locked     = locked_r;
   assign pm.lost       = lost_r;
   assign pm.reject_cnt = rej_r;
endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
module tb_period_meter;
   localparam int LOG2_AVG = 2;
   localparam int NAVG     = 1 << LOG2_AVG;
   localparam int P_MIN    = 4;
   localparam int P_MAX    = 1000;
   localparam int TIMEOUT  = 1100;

   logic clk;
   logic rst_n;
   logic [9:0] cnt_run;
   int n_tests;
   int n_fail;

   // Reference model state: window of accepted periods and the outputs
   // derived from it.
   bit m_started;
   int m_win[$];
   int m_period, m_avg, m_locked, m_lost, m_rej, m_avgv, m_since;
`ifdef PERIOD_METER_JITTER_EN
   int m_jit;
`endif

   period_meter_if pif();

   period_meter #(
      .LOG2_AVG(LOG2_AVG), .P_MIN(P_MIN), .P_MAX(P_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pm(pif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_started = 0; m_win.delete();
      m_period = 0; m_avg = 0; m_locked = 0; m_lost = 0; m_rej = 0;
      m_avgv = 0; m_since = 0;
`ifdef PERIOD_METER_JITTER_EN
      m_jit = 0;
`endif
   endtask

   // Advance the model by one clock cycle; g is the flag-to-flag distance.
   task automatic model_edge(input bit f);
      int g, p, sum, mn, mx;
      m_avgv = 0;
      if (!f) begin
         m_since++;
         if (m_started && m_since == TIMEOUT) begin
            m_lost = 1; m_locked = 0; m_started = 0; m_win.delete();
         end
      end else begin
         g = m_since + 1;
         m_since = 0;
         if (!m_started) begin
            m_started = 1; m_lost = 0; m_win.delete();
         end else begin
            p = ((g - 1) % 1024) + 1;
            if (p >= P_MIN && p <= P_MAX) begin
               m_period = p;
               m_win.push_back(p);
               if (m_win.size() == NAVG) begin
                  sum = 0; mn = 4096; mx = 0;
                  foreach (m_win[i]) begin
                     sum += m_win[i];
                     if (m_win[i] < mn) mn = m_win[i];
                     if (m_win[i] > mx) mx = m_win[i];
                  end
                  m_avg = sum / NAVG;
`ifdef PERIOD_METER_JITTER_EN
                  m_jit = mx - mn;
`endif
                  m_locked = 1; m_avgv = 1;
                  m_win.delete();
               end
            end else if (m_rej < 255) begin
               m_rej++;
            end
         end
      end
   endtask

   task automatic step(input bit f);
      pif.flag = f;
      cnt_run = f ? 10'd0 : cnt_run + 10'd1;
      pif.cnt = cnt_run;
      @(posedge clk);
      #1;
      model_edge(f);
   endtask

   task automatic run_gap(input int g);
      repeat (g - 1) step(1'b0);
      step(1'b1);
   endtask

   task automatic do_reset();
      pif.flag = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (pif.period !== 11'd0) begin n_fail++; $display("FAIL reset_period got %0d want 0", pif.period); end
      n_tests++; if (pif.period_avg !== 11'd0) begin n_fail++; $display("FAIL reset_avg got %0d want 0", pif.period_avg); end
      n_tests++; if ({pif.avg_valid, pif.locked, pif.lost} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {pif.avg_valid, pif.locked, pif.lost}); end
      n_tests++; if (pif.reject_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_rej got %0d want 0", pif.reject_cnt); end
      repeat (1200) step(1'b0);
      n_tests++; if (pif.lost !== 1'b0) begin n_fail++; $display("FAIL idle_no_timeout lost got %b want 0", pif.lost); end
   endtask

   task automatic test_steady();
      step(1'b1);
      n_tests++; if (pif.period !== 11'd0 || pif.avg_valid !== 1'b0) begin n_fail++; $display("FAIL start_marker period %0d avg_valid %b want 0 0", pif.period, pif.avg_valid); end
      for (int i = 0; i < 4; i++) begin
         run_gap(100);
         n_tests++; if (pif.period !== 11'd100) begin n_fail++; $display("FAIL steady_period[%0d] got %0d want 100", i, pif.period); end
         n_tests++; if (pif.avg_valid !== (i == 3)) begin n_fail++; $display("FAIL steady_avg_valid[%0d] got %b want %b", i, pif.avg_valid, i == 3); end
      end
      n_tests++; if (pif.period_avg !== 11'd100 || pif.locked !== 1'b1) begin n_fail++; $display("FAIL steady_avg got %0d locked %b want 100 1", pif.period_avg, pif.locked); end
      step(1'b0);
      n_tests++; if (pif.avg_valid !== 1'b0) begin n_fail++; $display("FAIL strobe_width avg_valid got %b want 0", pif.avg_valid); end
   endtask

   task automatic test_avg_trunc();
      int gaps[4] = '{98, 100, 102, 105};
      run_gap(gaps[0] - 1);
      for (int i = 1; i < 4; i++) run_gap(gaps[i]);
      n_tests++; if (pif.avg_valid !== 1'b1 || pif.period_avg !== 11'd101) begin n_fail++; $display("FAIL trunc_avg got %0d valid %b want 101 1", pif.period_avg, pif.avg_valid); end
      n_tests++; if (pif.period !== 11'd105) begin n_fail++; $display("FAIL trunc_period got %0d want 105", pif.period); end
   endtask

   task automatic test_glitch();
      int p0, r0;
      p0 = m_period; r0 = m_rej;
      run_gap(2);
      n_tests++; if (pif.reject_cnt !== 8'(r0 + 1)) begin n_fail++; $display("FAIL glitch_rej got %0d want %0d", pif.reject_cnt, r0 + 1); end
      n_tests++; if (pif.period !== 11'(p0)) begin n_fail++; $display("FAIL glitch_period got %0d want %0d", pif.period, p0); end
      run_gap(98);
      n_tests++; if (pif.period !== 11'd98) begin n_fail++; $display("FAIL glitch_next got %0d want 98", pif.period); end
      run_gap(100); run_gap(100);
      n_tests++; if (pif.avg_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_k3 avg_valid got %b want 0", pif.avg_valid); end
      run_gap(100);
      n_tests++; if (pif.avg_valid !== 1'b1 || pif.period_avg !== 11'd99) begin n_fail++; $display("FAIL glitch_avg got %0d valid %b want 99 1", pif.period_avg, pif.avg_valid); end
   endtask

   task automatic test_timeout();
      int p0;
      p0 = m_period;
      repeat (TIMEOUT - 1) step(1'b0);
      n_tests++; if (pif.lost !== 1'b0) begin n_fail++; $display("FAIL timeout_early lost got %b want 0", pif.lost); end
      step(1'b0);
      n_tests++; if (pif.lost !== 1'b1 || pif.locked !== 1'b0) begin n_fail++; $display("FAIL timeout_fire lost %b locked %b want 1 0", pif.lost, pif.locked); end
      repeat (1200 - TIMEOUT - 1) step(1'b0);
      step(1'b1);
      n_tests++; if (pif.lost !== 1'b0 || pif.period !== 11'(p0) || pif.avg_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_restart lost %b period %0d valid %b want 0 %0d 0", pif.lost, pif.period, pif.avg_valid, p0); end
      run_gap(100);
      n_tests++; if (pif.period !== 11'd100 || pif.locked !== 1'b0) begin n_fail++; $display("FAIL timeout_remeasure period %0d locked %b want 100 0", pif.period, pif.locked); end
   endtask

   task automatic test_flag_wins();
      run_gap(TIMEOUT);
      n_tests++; if (pif.lost !== 1'b0) begin n_fail++; $display("FAIL flag_wins lost got %b want 0", pif.lost); end
      n_tests++; if (pif.period !== 11'd76) begin n_fail++; $display("FAIL flag_wins_period got %0d want 76", pif.period); end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      while (m_win.size() != 2 && guard < 8) begin run_gap(100); guard++; end
      n_tests++; if (m_win.size() != 2) begin n_fail++; $display("FAIL async_setup window %0d want 2", m_win.size()); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({pif.period, pif.period_avg, pif.reject_cnt, pif.avg_valid, pif.locked, pif.lost} !== '0) begin n_fail++; $display("FAIL async_reset period %0d avg %0d rej %0d flags %b want all 0", pif.period, pif.period_avg, pif.reject_cnt, {pif.avg_valid, pif.locked, pif.lost}); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      step(1'b1);
      for (int i = 0; i < 4; i++) begin
         run_gap(100);
         n_tests++; if (pif.avg_valid !== (i == 3)) begin n_fail++; $display("FAIL async_restart_valid[%0d] got %b want %b", i, pif.avg_valid, i == 3); end
      end
   endtask

   task automatic test_reject_saturation();
      repeat (300) run_gap(1 + $urandom_range(0, 2));
      n_tests++; if (pif.reject_cnt !== 8'd255) begin n_fail++; $display("FAIL rej_saturate got %0d want 255", pif.reject_cnt); end
   endtask

   task automatic test_random();
      int r, g;
      do_reset();
      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      g = $urandom_range(1, 6);
         else if (r < 85) g = $urandom_range(7, 1000);
         else if (r < 95) g = $urandom_range(1001, 1100);
         else             g = $urandom_range(1101, 1250);
         for (int c = 1; c < g; c++) begin
            step(1'b0);
            n_tests++; if (pif.lost !== 1'(m_lost) || pif.avg_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_gap[%0d] lost %b valid %b want %0d 0", n, pif.lost, pif.avg_valid, m_lost); end
         end
         step(1'b1);
         n_tests++; if (pif.period !== 11'(m_period)) begin n_fail++; $display("FAIL rnd_period[%0d] got %0d want %0d", n, pif.period, m_period); end
         n_tests++; if (pif.avg_valid !== 1'(m_avgv) || pif.period_avg !== 11'(m_avg)) begin n_fail++; $display("FAIL rnd_avg[%0d] got %0d/%b want %0d/%0d", n, pif.period_avg, pif.avg_valid, m_avg, m_avgv); end
         n_tests++; if (pif.locked !== 1'(m_locked) || pif.lost !== 1'(m_lost)) begin n_fail++; $display("FAIL rnd_status[%0d] locked %b lost %b want %0d %0d", n, pif.locked, pif.lost, m_locked, m_lost); end
         n_tests++; if (pif.reject_cnt !== 8'(m_rej)) begin n_fail++; $display("FAIL rnd_rej[%0d] got %0d want %0d", n, pif.reject_cnt, m_rej); end
`ifdef PERIOD_METER_JITTER_EN
         n_tests++; if (pif.jitter !== 11'(m_jit)) begin n_fail++; $display("FAIL rnd_jitter[%0d] got %0d want %0d", n, pif.jitter, m_jit); end
`endif
      end
   endtask

`ifdef PERIOD_METER_JITTER_EN
   task automatic test_jitter();
      do_reset();
      n_tests++; if (pif.jitter !== 11'd0) begin n_fail++; $display("FAIL jitter_reset got %0d want 0", pif.jitter); end
      step(1'b1);
      run_gap(95); run_gap(105); run_gap(100); run_gap(100);
      n_tests++; if (pif.avg_valid !== 1'b1 || pif.jitter !== 11'd10 || pif.period_avg !== 11'd100) begin n_fail++; $display("FAIL jitter got %0d avg %0d valid %b want 10 100 1", pif.jitter, pif.period_avg, pif.avg_valid); end
   endtask
`endif

   initial begin
      n_tests = 0; n_fail = 0;
      cnt_run = '0;
      pif.flag = 1'b0;
      pif.cnt = '0;
      rst_n = 1'b0;
      model_reset();
      #12;
      test_reset();
      test_steady();
      test_avg_trunc();
      test_glitch();
      test_timeout();
      test_flag_wins();
      test_async_reset();
      test_reject_saturation();
      test_random();
`ifdef PERIOD_METER_JITTER_EN
      test_jitter();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
